gb_mem_responder: RTL and testbench

//  Bus responder on the sm83 memory interface: decodes addr/write/d_out from the core and returns d_in.

---
 rtl/gb_mem_responder.sv | 163 ++++++++++++++++
 tb/tb_gb_mem_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_mem_responder.sv
// SM83 bus responder: owns WRAM, OAM, HRAM, IE and the OAM DMA engine, and forwards
// ROM and IO accesses to external ports that answer like 1-clock synchronous RAMs.
module gb_mem_responder #(
  parameter int DMA_CYCLES = 4,
  parameter int WRAM_AW    = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        write,
  output logic [7:0]  rdata,
  output logic [14:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [6:0]  io_addr,
  output logic        io_we,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata,
  input  logic [7:0]  oam_raddr,
  output logic [7:0]  oam_rdata,
  output logic        dma_busy
);

  localparam int CW = (DMA_CYCLES > 1) ? $clog2(DMA_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DMA_CYCLES - 1);

  typedef enum logic [2:0] {
    REG_NONE, REG_ROM, REG_WRAM, REG_OAM, REG_IO, REG_DMA, REG_HRAM, REG_IE
  } region_t;
  typedef enum logic [2:0] {SEL_FF, SEL_ROM, SEL_IO, SEL_WRAM, SEL_INT} sel_t;
  typedef enum logic [1:0] {IDLE, START, ACTIVE} dma_state_t;

  logic [7:0] wram [1 << WRAM_AW];
  logic [7:0] oam  [160];
  logic [7:0] hram [128];

  logic [7:0]         ie_reg, dma_reg, int_q, wram_rd;
  sel_t               sel_q;
  dma_state_t         state;
  logic [CW-1:0]      cnt;
  logic [7:0]         idx;
  logic [7:0]         src_hi;
  region_t            region;
  logic               cpu_ok, cpu_we, slot_end;
  logic [7:0]         dma_byte;
  logic [12:0]        dma_wram_addr;
  logic [WRAM_AW-1:0] wram_raddr;

  always_comb begin
    region = REG_NONE;
    if (!addr[15]) region = REG_ROM;
    else if (addr[15:14] == 2'b11 && addr[15:9] != 7'h7F) region = REG_WRAM;
    else if (addr[15:8] == 8'hFE) region = (addr[7:0] < 8'hA0) ? REG_OAM : REG_NONE;
    else if (addr[15:8] == 8'hFF) begin
      if (addr[7:0] == 8'h46) region = REG_DMA;
      else if (!addr[7]) region = REG_IO;
      else if (addr[7:0] == 8'hFF) region = REG_IE;
      else region = REG_HRAM;
    end
  end

  // While DMA owns the bus the CPU only reaches the FFxx page.
  assign cpu_ok   = !dma_busy || (addr[15:8] == 8'hFF);
  assign cpu_we   = write && cpu_ok && rst;
  assign io_we    = write && (region == REG_IO);
  assign io_addr  = addr[6:0];
  assign io_wdata = wdata;

  assign dma_wram_addr = {src_hi[4:0], idx};
  assign wram_raddr    = dma_busy ? WRAM_AW'(dma_wram_addr) : addr[WRAM_AW-1:0];
  assign rom_addr      = !rst ? 15'h0000 : (dma_busy ? {src_hi[6:0], idx} : addr[14:0]);
  assign slot_end      = (state == ACTIVE) && (cnt == CNT_LAST);

  always_comb begin
    dma_byte = 8'hFF;
    if (!src_hi[7]) dma_byte = rom_data;
    else if (src_hi[7:6] == 2'b11) dma_byte = wram_rd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      src_hi   <= '0;
      dma_busy <= 1'b0;
      dma_reg  <= 8'hFF;
    end else if (cpu_we && region == REG_DMA) begin
      dma_reg  <= wdata;
      src_hi   <= wdata;
      idx      <= '0;
      cnt      <= '0;
      state    <= START;
      dma_busy <= 1'b1;
    end else begin
      case (state)
        START: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= ACTIVE;
          end else cnt <= cnt + 1'b1;
        end
        ACTIVE: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (idx == 8'd159) begin
              state    <= IDLE;
              dma_busy <= 1'b0;
            end else idx <= idx + 8'd1;
          end else cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q     <= SEL_FF;
      int_q     <= 8'hFF;
      ie_reg    <= 8'h00;
      oam_rdata <= 8'hFF;
    end else begin
      sel_q <= SEL_FF;
      int_q <= 8'hFF;
      if (cpu_ok) begin
        case (region)
          REG_ROM:  sel_q <= SEL_ROM;
          REG_WRAM: sel_q <= SEL_WRAM;
          REG_IO:   sel_q <= SEL_IO;
          REG_OAM:  begin sel_q <= SEL_INT; int_q <= oam[addr[7:0]];  end
          REG_DMA:  begin sel_q <= SEL_INT; int_q <= dma_reg;         end
          REG_HRAM: begin sel_q <= SEL_INT; int_q <= hram[addr[6:0]]; end
          REG_IE:   begin sel_q <= SEL_INT; int_q <= ie_reg;          end
          default:  sel_q <= SEL_FF;
        endcase
      end
      if (cpu_we && region == REG_IE) ie_reg <= wdata;
      oam_rdata <= (oam_raddr < 8'd160) ? oam[oam_raddr] : 8'hFF;
    end
  end

  // RAM arrays keep their contents across reset; the WRAM port is shared with DMA.
  always_ff @(posedge clk) begin
    wram_rd <= wram[wram_raddr];
    if (cpu_we && region == REG_WRAM) wram[addr[WRAM_AW-1:0]] <= wdata;
    if (cpu_we && region == REG_HRAM) hram[addr[6:0]] <= wdata;
    if (rst && slot_end) oam[idx] <= dma_byte;
    else if (cpu_we && region == REG_OAM) oam[addr[7:0]] <= wdata;
  end

  always_comb begin
    rdata = 8'hFF;
    case (sel_q)
      SEL_ROM:  rdata = rom_data;
      SEL_IO:   rdata = io_rdata;
      SEL_WRAM: rdata = wram_rd;
      SEL_INT:  rdata = int_q;
      default:  rdata = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_gb_mem_responder.sv
// Scoreboard bench for gb_mem_responder: stimulus queues expected bytes, a negedge
// monitor pops them whenever a tagged read result is due on rdata or oam_rdata.
module tb_gb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        write;
  logic [7:0]  rdata;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data;
  logic [6:0]  io_addr;
  logic        io_we;
  logic [7:0]  io_wdata;
  logic [7:0]  io_rdata;
  logic [7:0]  oam_raddr;
  logic [7:0]  oam_rdata;
  logic        dma_busy;

  typedef struct {
    int          kind;
    logic [15:0] tag;
    logic [7:0]  exp;
  } exp_t;

  exp_t       sb[$];
  int         issue_kind = 0;
  int         seen_kind  = 0;
  int         n_vec = 0;
  int         n_bad = 0;
  int         cycles;
  int         exp_ra;
  logic [7:0] io_mem [128];

  gb_mem_responder #(.DMA_CYCLES(4), .WRAM_AW(13)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .write(write), .rdata(rdata),
    .rom_addr(rom_addr), .rom_data(rom_data), .io_addr(io_addr), .io_we(io_we),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .oam_raddr(oam_raddr),
    .oam_rdata(oam_rdata), .dma_busy(dma_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'hA5;
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  always @(posedge clk) begin
    if (io_we) io_mem[io_addr] <= io_wdata;
    io_rdata <= io_mem[io_addr];
  end

  always @(posedge clk) seen_kind <= issue_kind;

  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [7:0] act;
    if (seen_kind != 0) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("[TB] FAIL sb_underflow: read result presented with no expected entry");
      end else begin
        e   = sb.pop_front();
        act = (e.kind == 2) ? oam_rdata : rdata;
        if (act !== e.exp) begin
          n_bad++;
          $display("[TB] FAIL %s %h: got %h expected %h",
                   (e.kind == 2) ? "oam_rdata" : "rdata", e.tag, act, e.exp);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    write      = 1'b0;
    issue_kind = 0;
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d, input logic w,
                               input logic chk, input logic [7:0] exp_v);
    exp_t e;
    addr  = a;
    wdata = d;
    write = w;
    if (chk) begin
      e.kind = 1;
      e.tag  = a;
      e.exp  = exp_v;
      sb.push_back(e);
      issue_kind = 1;
    end
    step();
  endtask

  task automatic readOam(input logic [7:0] idx, input logic [7:0] exp_v);
    exp_t e;
    oam_raddr  = idx;
    e.kind     = 2;
    e.tag      = {8'h00, idx};
    e.exp      = exp_v;
    sb.push_back(e);
    issue_kind = 2;
    step();
  endtask

  task automatic fillWram(input logic [15:0] base, input logic [7:0] pat);
    for (int i = 0; i < 160; i++) applyStimulus(16'(base + 16'(i)), 8'(i) ^ pat, 1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b0; addr = 16'h0000; wdata = 8'h00; write = 1'b0; oam_raddr = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rdata", 16'(rdata), 16'h00FF);
    checkOutput("reset_dma_busy", 16'(dma_busy), 16'h0000);
    checkOutput("reset_oam_rdata", 16'(oam_rdata), 16'h00FF);
    checkOutput("reset_rom_addr", 16'(rom_addr), 16'h0000);
    rst = 1'b1;
    step();

    $display("[TB] reset values and register map");
    applyStimulus(16'hFF46, 8'h00, 1'b0, 1'b1, 8'hFF);
    applyStimulus(16'hFFFF, 8'h00, 1'b0, 1'b1, 8'h00);
    applyStimulus(16'hC123, 8'h5A, 1'b1, 1'b0, 8'h00);
    applyStimulus(16'hC123, 8'h00, 1'b0, 1'b1, 8'h5A);
    applyStimulus(16'hE123, 8'h00, 1'b0, 1'b1, 8'h5A);
    applyStimulus(16'hC123, 8'h77, 1'b1, 1'b1, 8'h5A);
    applyStimulus(16'hC123, 8'h00, 1'b0, 1'b1, 8'h77);
    applyStimulus(16'h8000, 8'h00, 1'b0, 1'b1, 8'hFF);
    applyStimulus(16'hBFFF, 8'h00, 1'b0, 1'b1, 8'hFF);
    applyStimulus(16'hFEA0, 8'h00, 1'b0, 1'b1, 8'hFF);
    applyStimulus(16'h0123, 8'h00, 1'b0, 1'b1, 8'h87);
    applyStimulus(16'h7FFF, 8'h00, 1'b0, 1'b1, 8'h25);

    $display("[TB] HRAM, IE and IO forwarding");
    applyStimulus(16'hFF80, 8'h11, 1'b1, 1'b0, 8'h00);
    applyStimulus(16'hFFFF, 8'h1F, 1'b1, 1'b0, 8'h00);
    applyStimulus(16'hFFFE, 8'h9C, 1'b1, 1'b0, 8'h00);
    addr = 16'hFF01; wdata = 8'hAB; write = 1'b1;
    #1;
    checkOutput("io_we_ff01", 16'(io_we), 16'h0001);
    checkOutput("io_addr_ff01", 16'(io_addr), 16'h0001);
    checkOutput("io_wdata_ff01", 16'(io_wdata), 16'h00AB);
    step();
    applyStimulus(16'hFF80, 8'h00, 1'b0, 1'b1, 8'h11);
    applyStimulus(16'hFFFF, 8'h00, 1'b0, 1'b1, 8'h1F);
    applyStimulus(16'hFFFE, 8'h00, 1'b0, 1'b1, 8'h9C);
    applyStimulus(16'hFF01, 8'h00, 1'b0, 1'b1, 8'hAB);

    $display("[TB] DMA from WRAM C000");
    fillWram(16'hC000, 8'h55);
    addr = 16'hFF46; wdata = 8'hC0; write = 1'b1;
    #1;
    checkOutput("io_we_ff46", 16'(io_we), 16'h0000);
    step();
    cycles = 0;
    while (dma_busy && cycles < 2000) begin
      cycles++;
      if (cycles == 10)       applyStimulus(16'hC000, 8'h00, 1'b0, 1'b1, 8'hFF);
      else if (cycles == 11)  applyStimulus(16'hFF80, 8'h00, 1'b0, 1'b1, 8'h11);
      else if (cycles == 12)  applyStimulus(16'h0123, 8'h00, 1'b0, 1'b1, 8'hFF);
      else if (cycles == 300) applyStimulus(16'hC000, 8'hEE, 1'b1, 1'b0, 8'h00);
      else if (cycles == 301) applyStimulus(16'hFF46, 8'h00, 1'b0, 1'b1, 8'hC0);
      else step();
    end
    checkOutput("dma_busy_len_c0", 16'(cycles), 16'd644);
    applyStimulus(16'hC000, 8'h00, 1'b0, 1'b1, 8'h55);
    for (int i = 0; i < 160; i++) readOam(8'(i), 8'(i) ^ 8'h55);
    readOam(8'd160, 8'hFF);
    readOam(8'd255, 8'hFF);
    applyStimulus(16'hFE05, 8'h00, 1'b0, 1'b1, 8'h50);
    applyStimulus(16'hFE9F, 8'h00, 1'b0, 1'b1, 8'hCA);

    $display("[TB] DMA from ROM 1200");
    applyStimulus(16'hFF46, 8'h12, 1'b1, 1'b0, 8'h00);
    cycles = 0;
    while (dma_busy && cycles < 2000) begin
      if (cycles % 4 == 2) begin
        exp_ra = 'h1200 + ((cycles < 4) ? 0 : (cycles - 4) / 4);
        checkOutput("rom_addr_dma", 16'(rom_addr), 16'(exp_ra));
      end
      cycles++;
      step();
    end
    checkOutput("dma_busy_len_rom", 16'(cycles), 16'd644);
    readOam(8'd0, 8'hB7);
    readOam(8'd159, 8'h28);
    for (int i = 0; i < 160; i++) readOam(8'(i), rom_fn(15'(16'h1200 + 16'(i))));

    $display("[TB] DMA restart at slot 50");
    fillWram(16'hD000, 8'hA3);
    applyStimulus(16'hFF46, 8'hC0, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 205; k++) step();
    checkOutput("busy_before_restart", 16'(dma_busy), 16'h0001);
    applyStimulus(16'hFF46, 8'hD0, 1'b1, 1'b0, 8'h00);
    cycles = 0;
    while (dma_busy && cycles < 2000) begin
      cycles++;
      step();
    end
    checkOutput("dma_busy_len_restart", 16'(cycles), 16'd644);
    for (int i = 0; i < 160; i++) readOam(8'(i), 8'(i) ^ 8'hA3);

    $display("[TB] reset during DMA slot 20");
    applyStimulus(16'hFF46, 8'hC0, 1'b1, 1'b0, 8'h00);
    repeat (85) step();
    rst = 1'b0;
    #1;
    checkOutput("abort_dma_busy", 16'(dma_busy), 16'h0000);
    checkOutput("abort_rdata", 16'(rdata), 16'h00FF);
    step();
    rst = 1'b1;
    step();
    for (int i = 0; i < 160; i++) readOam(8'(i), 8'(i) ^ ((i < 20) ? 8'h55 : 8'hA3));
    applyStimulus(16'hFF46, 8'h00, 1'b0, 1'b1, 8'hFF);
    applyStimulus(16'hFFFF, 8'h00, 1'b0, 1'b1, 8'h00);
    checkOutput("post_abort_busy", 16'(dma_busy), 16'h0000);

    repeat (2) step();
    checkOutput("scoreboard_drained", 16'(sb.size()), 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
